zap_wb_arb: RTL and testbench

Two-master Wishbone B3 arbiter that shares the single external memory bus between the instruction-side and data-side cache/MMU complexes. Each side presents its combinational next-cycle bus request (`*_nxt` signals). The arbiter picks an owner with round-robin fairness and holds ownership for a whole cycle, including bursts. It registers the selected request onto the bus and routes `i_wb_ack` back to the owner only.

---
 rtl/zap_wb_arb_pkg.sv | 26 ++
 rtl/zap_wb_arb_rr.sv | 20 ++
 rtl/zap_wb_arb.sv | 172 +++++++++++++++++
 tb/tb_zap_wb_arb.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_wb_arb_pkg.sv
// Shared types and constants for the ZAP two-master Wishbone arbiter.
// CTI codes match the values used by the rest of the ZAP bus blocks.
package zap_wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_BURST   = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   // One-hot owner vector for a given arbiter state; idle maps to 2'b00.
   function automatic logic [1:0] gnt_onehot(input arb_state_t s);
      logic [1:0] v;
      case (s)
         GNT0:    v = 2'b01;
         GNT1:    v = 2'b10;
         default: v = 2'b00;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/zap_wb_arb_rr.sv
// Combinational two-way round-robin picker: on a tie, the master that
// did not own the bus last wins.
module zap_wb_arb_rr (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] pick
);

   // Priority resolution between the two requesters.
   always_comb begin
      pick = 2'b00;
      case (req)
         2'b01:   pick = 2'b01;
         2'b10:   pick = 2'b10;
         2'b11:   pick = last ? 2'b01 : 2'b10;
         default: pick = 2'b00;
      endcase
   end

endmodule

// File: rtl/zap_wb_arb.sv
// Two-master Wishbone B3 arbiter: round-robin ownership held for a whole
// cycle (bursts included), registered bus outputs, ack routed to the owner.
module zap_wb_arb
   import zap_wb_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_m0_wb_cyc_nxt,
   input  logic                  i_m0_wb_stb_nxt,
   input  logic                  i_m0_wb_wen_nxt,
   input  logic [DATA_W/8-1:0]   i_m0_wb_sel_nxt,
   input  logic [DATA_W-1:0]     i_m0_wb_dat_nxt,
   input  logic [ADDR_W-1:0]     i_m0_wb_adr_nxt,
   input  logic [2:0]            i_m0_wb_cti_nxt,
   input  logic                  i_m1_wb_cyc_nxt,
   input  logic                  i_m1_wb_stb_nxt,
   input  logic                  i_m1_wb_wen_nxt,
   input  logic [DATA_W/8-1:0]   i_m1_wb_sel_nxt,
   input  logic [DATA_W-1:0]     i_m1_wb_dat_nxt,
   input  logic [ADDR_W-1:0]     i_m1_wb_adr_nxt,
   input  logic [2:0]            i_m1_wb_cti_nxt,
   output logic                  o_m0_wb_ack,
   output logic                  o_m1_wb_ack,
   output logic                  o_wb_cyc,
   output logic                  o_wb_stb,
   output logic                  o_wb_wen,
   output logic [DATA_W/8-1:0]   o_wb_sel,
   output logic [DATA_W-1:0]     o_wb_dat,
   output logic [ADDR_W-1:0]     o_wb_adr,
   output logic [2:0]            o_wb_cti,
   output logic                  o_wb_cyc_nxt,
   output logic                  o_wb_stb_nxt,
   output logic                  o_wb_wen_nxt,
   output logic [DATA_W/8-1:0]   o_wb_sel_nxt,
   output logic [DATA_W-1:0]     o_wb_dat_nxt,
   output logic [ADDR_W-1:0]     o_wb_adr_nxt,
   output logic [2:0]            o_wb_cti_nxt,
   input  logic                  i_wb_ack,
   input  logic [DATA_W-1:0]     i_wb_dat,
   output logic [1:0]            o_gnt
);

   arb_state_t                r_state;
   arb_state_t                w_state_nxt;
   logic                      r_last;
   logic [1:0]                r_gnt;
   logic                      r_wb_cyc;
   logic                      r_wb_stb;
   logic                      r_wb_wen;
   logic [DATA_W/8-1:0]       r_wb_sel;
   logic [DATA_W-1:0]         r_wb_dat;
   logic [ADDR_W-1:0]         r_wb_adr;
   logic [2:0]                r_wb_cti;
   logic [1:0]                w_pick;
   logic                      w_win;
   logic                      w_unused_dat;

   // Read data fans out to both masters outside this block.
   assign w_unused_dat = ^i_wb_dat;

   // Ownership may only change when no beat is pending on the bus.
   assign w_win = !r_wb_stb || i_wb_ack;

   zap_wb_arb_rr u_rr (
      .req  ({i_m1_wb_cyc_nxt, i_m0_wb_cyc_nxt}),
      .last (r_last),
      .pick (w_pick)
   );

   // Next owner: hold through cycles/bursts, hand over without a bubble.
   always_comb begin
      w_state_nxt = r_state;
      if (w_win) begin
         case (r_state)
            IDLE: begin
               if (w_pick[0])      w_state_nxt = GNT0;
               else if (w_pick[1]) w_state_nxt = GNT1;
               else                w_state_nxt = IDLE;
            end
            GNT0: begin
               if (i_m0_wb_cyc_nxt)      w_state_nxt = GNT0;
               else if (i_m1_wb_cyc_nxt) w_state_nxt = GNT1;
               else                      w_state_nxt = IDLE;
            end
            GNT1: begin
               if (i_m1_wb_cyc_nxt)      w_state_nxt = GNT1;
               else if (i_m0_wb_cyc_nxt) w_state_nxt = GNT0;
               else                      w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Bus mux; when idle the data-path fields hold so the bus does not toggle.
   always_comb begin
      o_wb_cyc_nxt = 1'b0;
      o_wb_stb_nxt = 1'b0;
      o_wb_wen_nxt = r_wb_wen;
      o_wb_sel_nxt = r_wb_sel;
      o_wb_dat_nxt = r_wb_dat;
      o_wb_adr_nxt = r_wb_adr;
      o_wb_cti_nxt = CTI_EOB;
      case (w_state_nxt)
         GNT0: begin
            o_wb_cyc_nxt = i_m0_wb_cyc_nxt;
            o_wb_stb_nxt = i_m0_wb_stb_nxt;
            o_wb_wen_nxt = i_m0_wb_wen_nxt;
            o_wb_sel_nxt = i_m0_wb_sel_nxt;
            o_wb_dat_nxt = i_m0_wb_dat_nxt;
            o_wb_adr_nxt = i_m0_wb_adr_nxt;
            o_wb_cti_nxt = i_m0_wb_cti_nxt;
         end
         GNT1: begin
            o_wb_cyc_nxt = i_m1_wb_cyc_nxt;
            o_wb_stb_nxt = i_m1_wb_stb_nxt;
            o_wb_wen_nxt = i_m1_wb_wen_nxt;
            o_wb_sel_nxt = i_m1_wb_sel_nxt;
            o_wb_dat_nxt = i_m1_wb_dat_nxt;
            o_wb_adr_nxt = i_m1_wb_adr_nxt;
            o_wb_cti_nxt = i_m1_wb_cti_nxt;
         end
         default: o_wb_cyc_nxt = 1'b0;
      endcase
   end

   // Arbiter state, last-owner memory and registered bus outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= IDLE;
         r_last   <= 1'b1;
         r_gnt    <= 2'b00;
         r_wb_cyc <= 1'b0;
         r_wb_stb <= 1'b0;
         r_wb_wen <= 1'b0;
         r_wb_sel <= '0;
         r_wb_dat <= '0;
         r_wb_adr <= '0;
         r_wb_cti <= CTI_EOB;
      end else begin
         r_state  <= w_state_nxt;
         r_gnt    <= gnt_onehot(w_state_nxt);
         if (w_state_nxt == GNT0)      r_last <= 1'b0;
         else if (w_state_nxt == GNT1) r_last <= 1'b1;
         else                          r_last <= r_last;
         r_wb_cyc <= o_wb_cyc_nxt;
         r_wb_stb <= o_wb_stb_nxt;
         r_wb_wen <= o_wb_wen_nxt;
         r_wb_sel <= o_wb_sel_nxt;
         r_wb_dat <= o_wb_dat_nxt;
         r_wb_adr <= o_wb_adr_nxt;
         r_wb_cti <= o_wb_cti_nxt;
      end
   end

   assign o_m0_wb_ack = i_wb_ack && (r_state == GNT0);
   assign o_m1_wb_ack = i_wb_ack && (r_state == GNT1);
   assign o_gnt       = r_gnt;
   assign o_wb_cyc    = r_wb_cyc;
   assign o_wb_stb    = r_wb_stb;
   assign o_wb_wen    = r_wb_wen;
   assign o_wb_sel    = r_wb_sel;
   assign o_wb_dat    = r_wb_dat;
   assign o_wb_adr    = r_wb_adr;
   assign o_wb_cti    = r_wb_cti;

endmodule

// File: tb/tb_zap_wb_arb.sv
// Scoreboard bench for zap_wb_arb: behavioural masters and slave, expected
// acks queued by the stimulus and popped by a monitor on each routed ack.
module tb_zap_wb_arb;

   typedef struct packed {
      logic [31:0] adr;
      logic [2:0]  cti;
      logic        wen;
      logic        eoc;
   } beat_t;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        m0_cyc, m0_stb, m0_wen, m1_cyc, m1_stb, m1_wen;
   logic [3:0]  m0_sel, m1_sel;
   logic [31:0] m0_dat, m0_adr, m1_dat, m1_adr;
   logic [2:0]  m0_cti, m1_cti;
   logic        o_m0_wb_ack, o_m1_wb_ack;
   logic        o_wb_cyc, o_wb_stb, o_wb_wen;
   logic [3:0]  o_wb_sel;
   logic [31:0] o_wb_dat, o_wb_adr;
   logic [2:0]  o_wb_cti;
   logic        n_cyc, n_stb, n_wen;
   logic [3:0]  n_sel;
   logic [31:0] n_dat, n_adr;
   logic [2:0]  n_cti;
   logic        i_wb_ack;
   logic [31:0] i_wb_dat;
   logic [1:0]  o_gnt;

   beat_t b0 [16];
   beat_t b1 [16];
   int    n0, n1, idx0, idx1, cnt, wait_cyc;
   logic  mrst, stall, ack_force;
   logic  v0, v1;
   beat_t c0, c1;
   logic [33:0] exp_q [$];
   int    n_checks = 0;
   int    n_errors = 0;

   always #5 clk = ~clk;

   zap_wb_arb dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_m0_wb_cyc_nxt(m0_cyc), .i_m0_wb_stb_nxt(m0_stb), .i_m0_wb_wen_nxt(m0_wen),
      .i_m0_wb_sel_nxt(m0_sel), .i_m0_wb_dat_nxt(m0_dat), .i_m0_wb_adr_nxt(m0_adr),
      .i_m0_wb_cti_nxt(m0_cti),
      .i_m1_wb_cyc_nxt(m1_cyc), .i_m1_wb_stb_nxt(m1_stb), .i_m1_wb_wen_nxt(m1_wen),
      .i_m1_wb_sel_nxt(m1_sel), .i_m1_wb_dat_nxt(m1_dat), .i_m1_wb_adr_nxt(m1_adr),
      .i_m1_wb_cti_nxt(m1_cti),
      .o_m0_wb_ack(o_m0_wb_ack), .o_m1_wb_ack(o_m1_wb_ack),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_wen(o_wb_wen),
      .o_wb_sel(o_wb_sel), .o_wb_dat(o_wb_dat), .o_wb_adr(o_wb_adr), .o_wb_cti(o_wb_cti),
      .o_wb_cyc_nxt(n_cyc), .o_wb_stb_nxt(n_stb), .o_wb_wen_nxt(n_wen),
      .o_wb_sel_nxt(n_sel), .o_wb_dat_nxt(n_dat), .o_wb_adr_nxt(n_adr), .o_wb_cti_nxt(n_cti),
      .i_wb_ack(i_wb_ack), .i_wb_dat(i_wb_dat), .o_gnt(o_gnt)
   );

   // Master models: present the current beat, or the following one in the ack cycle.
   always_comb begin
      v0 = 1'b0;
      c0 = '0;
      if (o_m0_wb_ack && b0[idx0].eoc) v0 = 1'b0;
      else if (o_m0_wb_ack) begin
         if (idx0 + 1 < n0) begin v0 = 1'b1; c0 = b0[idx0 + 1]; end
      end else if (idx0 < n0) begin v0 = 1'b1; c0 = b0[idx0]; end
   end

   always_comb begin
      v1 = 1'b0;
      c1 = '0;
      if (o_m1_wb_ack && b1[idx1].eoc) v1 = 1'b0;
      else if (o_m1_wb_ack) begin
         if (idx1 + 1 < n1) begin v1 = 1'b1; c1 = b1[idx1 + 1]; end
      end else if (idx1 < n1) begin v1 = 1'b1; c1 = b1[idx1]; end
   end

   assign m0_cyc = v0;  assign m0_stb = v0;  assign m0_wen = c0.wen;  assign m0_sel = 4'hF;
   assign m0_adr = c0.adr;  assign m0_dat = c0.adr ^ 32'hA5A5_0000;  assign m0_cti = c0.cti;
   assign m1_cyc = v1;  assign m1_stb = v1;  assign m1_wen = c1.wen;  assign m1_sel = 4'hF;
   assign m1_adr = c1.adr;  assign m1_dat = c1.adr ^ 32'hA5A5_0000;  assign m1_cti = c1.cti;
   assign i_wb_dat = 32'hDEAD_BEEF;

   always_ff @(posedge clk) begin
      if (mrst) begin idx0 <= 0; idx1 <= 0; end
      else begin
         if (o_m0_wb_ack) idx0 <= idx0 + 1;
         if (o_m1_wb_ack) idx1 <= idx1 + 1;
      end
   end

   // Slave model: ack once wait_cyc cycles have elapsed with stb high.
   always_ff @(posedge clk) begin
      if (mrst || i_reset) cnt <= 0;
      else if (o_wb_stb && !i_wb_ack) cnt <= cnt + 1;
      else cnt <= 0;
   end
   assign i_wb_ack = ack_force || (o_wb_stb && !stall && (cnt >= wait_cyc));

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every routed ack must match the next queued {ack1, ack0, adr}.
   always @(negedge clk) begin
      if (o_m0_wb_ack || o_m1_wb_ack) begin
         if (exp_q.size() == 0) begin
            n_checks = n_checks + 1;
            n_errors = n_errors + 1;
            $display("FAIL unexpected_ack: got acks=%b adr=%0h expected none",
                     {o_m1_wb_ack, o_m0_wb_ack}, o_wb_adr);
         end else begin
            chk("ack_order", {94'd0, o_m1_wb_ack, o_m0_wb_ack, o_wb_adr}, {94'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic restart();
      mrst = 1'b1; n0 = 0; n1 = 0;
      @(posedge clk); #1;
      mrst = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      chk("drain", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   function automatic beat_t mk(input logic [31:0] a, input logic [2:0] t, input logic w, input logic e);
      beat_t b;
      b.adr = a; b.cti = t; b.wen = w; b.eoc = e;
      return b;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int run, m0_during, acks;
      i_reset = 1'b1; mrst = 1'b1; stall = 1'b0; ack_force = 1'b0; wait_cyc = 1;
      n0 = 0; n1 = 0;
      // 1: reset values with both masters requesting, then first grant to m0
      b0[0] = mk(32'h0000_1000, 3'b111, 1'b0, 1'b1);
      b1[0] = mk(32'h0000_2000, 3'b111, 1'b0, 1'b1);
      n0 = 1; n1 = 1;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_cyc", o_wb_cyc, 0);   chk("rst_stb", o_wb_stb, 0);
      chk("rst_wen", o_wb_wen, 0);   chk("rst_sel", o_wb_sel, 0);
      chk("rst_dat", o_wb_dat, 0);   chk("rst_adr", o_wb_adr, 0);
      chk("rst_cti", o_wb_cti, 3'b111); chk("rst_gnt", o_gnt, 0);
      chk("rst_acks", {o_m1_wb_ack, o_m0_wb_ack}, 0);
      exp_q.push_back({2'b01, 32'h0000_1000});
      exp_q.push_back({2'b10, 32'h0000_2000});
      i_reset = 1'b0; mrst = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("first_gnt", o_gnt, 2'b01);
      chk("first_adr", o_wb_adr, 32'h0000_1000);
      chk("first_cyc", {o_wb_cyc, o_wb_stb}, 2'b11);
      drain();

      // 2: tie alternation with single reads, one wait state
      restart();
      for (int i = 0; i < 3; i++) begin
         b0[i] = mk(32'h0000_1100 + 32'(4 * i), 3'b111, 1'b0, 1'b1);
         b1[i] = mk(32'h0000_2100 + 32'(4 * i), 3'b111, 1'b0, 1'b1);
         exp_q.push_back({2'b01, 32'h0000_1100 + 32'(4 * i)});
         exp_q.push_back({2'b10, 32'h0000_2100 + 32'(4 * i)});
      end
      n0 = 3; n1 = 3;
      drain();

      // 3: burst lock, m0 requests from beat 2, zero-wait slave
      restart();
      wait_cyc = 0;
      for (int i = 0; i < 8; i++) begin
         b1[i] = mk(32'h0000_3000 + 32'(4 * i), (i < 7) ? 3'b010 : 3'b111, 1'b0, (i == 7));
         exp_q.push_back({2'b10, 32'h0000_3000 + 32'(4 * i)});
      end
      b0[0] = mk(32'h0000_1200, 3'b111, 1'b0, 1'b1);
      exp_q.push_back({2'b01, 32'h0000_1200});
      n1 = 8;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_m1_wb_ack) break;
      end
      n0 = 1;
      run = 0; m0_during = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (o_m1_wb_ack) run = run + 1;
         if (o_m0_wb_ack) m0_during = m0_during + 1;
      end
      chk("burst_contig", run, 7);
      chk("burst_no_m0_ack", m0_during, 0);
      @(negedge clk);
      chk("handover", {o_gnt, o_wb_stb, o_wb_adr}, {2'b01, 1'b1, 32'h0000_1200});
      drain();

      // 4: stalled slave, other master waiting; m1 wins the tie (m0 owned last)
      restart();
      wait_cyc = 1; stall = 1'b1;
      b0[0] = mk(32'h0000_1300, 3'b111, 1'b0, 1'b1);
      b1[0] = mk(32'h0000_2300, 3'b111, 1'b1, 1'b1);
      exp_q.push_back({2'b10, 32'h0000_2300});
      exp_q.push_back({2'b01, 32'h0000_1300});
      n0 = 1; n1 = 1;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_bus", {o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_sel, o_wb_dat, o_wb_adr, o_wb_cti},
             {1'b1, 1'b1, 1'b1, 4'hF, 32'h0000_2300 ^ 32'hA5A5_0000, 32'h0000_2300, 3'b111});
         chk("stall_gnt", o_gnt, 2'b10);
      end
      stall = 1'b0;
      drain();

      // 5: stray ack while idle
      restart();
      @(posedge clk); #1;
      ack_force = 1'b1;
      @(negedge clk);
      chk("stray_acks", {o_m1_wb_ack, o_m0_wb_ack}, 2'b00);
      chk("stray_gnt", o_gnt, 2'b00);
      @(posedge clk); #1;
      ack_force = 1'b0;
      @(negedge clk);
      chk("stray_idle", {o_gnt, o_wb_cyc}, 3'b000);

      // 6: reset during beat 3 of a 4-beat write burst
      restart();
      wait_cyc = 1;
      for (int i = 0; i < 4; i++)
         b0[i] = mk(32'h0000_4000 + 32'(4 * i), (i < 3) ? 3'b010 : 3'b111, 1'b1, (i == 3));
      exp_q.push_back({2'b01, 32'h0000_4000});
      exp_q.push_back({2'b01, 32'h0000_4004});
      n0 = 4;
      acks = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (o_m0_wb_ack) acks = acks + 1;
         if (acks == 2) break;
      end
      chk("pre_reset_acks", acks, 2);
      @(posedge clk); #1;
      chk("beat3_on_bus", o_wb_adr, 32'h0000_4008);
      i_reset = 1'b1; mrst = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("midrst_cyc_cti", {o_wb_cyc, o_wb_stb, o_wb_cti}, {1'b0, 1'b0, 3'b111});
      chk("midrst_gnt", o_gnt, 2'b00);
      b0[0] = mk(32'h0000_1400, 3'b111, 1'b0, 1'b1);
      b1[0] = mk(32'h0000_2400, 3'b111, 1'b0, 1'b1);
      n0 = 1; n1 = 1;
      exp_q.push_back({2'b01, 32'h0000_1400});
      exp_q.push_back({2'b10, 32'h0000_2400});
      @(posedge clk); #1;
      i_reset = 1'b0; mrst = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("postrst_gnt", {o_gnt, o_wb_adr}, {2'b01, 32'h0000_1400});
      drain();

      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
